// File: rtl/paddle_ai.sv
// Computer-controlled pong paddle: re-centres while the ball recedes and tracks
// ball row after a reaction delay once the ball is approaching.
module paddle_ai #(
   parameter int GAME_WIDTH    = 40,
   parameter int GAME_HEIGHT   = 30,
   parameter int PADDLE_X      = 39,
   parameter int PADDLE_HEIGHT = 6,
   parameter int REACT_TICKS   = 625000,
   parameter int DEAD_ZONE     = 1
) (
   input  logic       clock,
   input  logic       ireset_n,
   input  logic       game_active,
   input  logic [5:0] iballx,
   input  logic [5:0] ibally,
   input  logic       iballdx,
   input  logic [5:0] ipaddley,
   output logic       oup,
   output logic       odown,
   output logic [1:0] ostate
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CENTER = 2'd1,
      WAIT   = 2'd2,
      TRACK  = 2'd3
   } state_t;

   localparam logic              RIGHT_SIDE   = (PADDLE_X >= GAME_WIDTH / 2);
   localparam logic signed [7:0] CENTRE_ROW   = 8'(GAME_HEIGHT / 2);
   localparam logic        [7:0] HALF_PADDLE  = 8'(PADDLE_HEIGHT / 2);
   localparam logic signed [7:0] DZ           = 8'(DEAD_ZONE);
   localparam logic        [5:0] BOTTOM_LIMIT = 6'(GAME_HEIGHT - PADDLE_HEIGHT);
   localparam logic       [31:0] LAST_TICK    = 32'(REACT_TICKS - 1);

   state_t             state_p1, state_nxt;
   logic        [31:0] cnt_p1, cnt_nxt;
   logic               up_p1, down_p1;
   logic signed  [7:0] target_p0;
   logic         [1:0] steer_p0;
   logic               approaching;

   // Ball column carries no decision information; kept only for port compatibility.
   logic unused_ballx;
   assign unused_ballx = ^iballx;

   // Returns {up, down}; the dead zone and playfield edges gate each request.
   function automatic logic [1:0] steer(input logic signed [7:0] target,
                                        input logic        [5:0] paddley);
      logic signed [7:0] centre;
      logic signed [7:0] err;
      logic              up;
      logic              dn;
      centre = signed'({2'b00, paddley} + HALF_PADDLE);
      err    = target - centre;
      dn     = (err > DZ) && (paddley < BOTTOM_LIMIT);
      up     = (err < -DZ) && (paddley != 6'd0);
      return {up, dn};
   endfunction

   assign approaching = RIGHT_SIDE ? iballdx : ~iballdx;

   // Stage p0: next-state and steering decision from the current state
   always_comb begin
      state_nxt = state_p1;
      cnt_nxt   = cnt_p1;
      target_p0 = CENTRE_ROW;
      steer_p0  = 2'b00;

      if (state_p1 == TRACK) begin
         target_p0 = signed'({2'b00, ibally});
      end
      if ((state_p1 == CENTER) || (state_p1 == TRACK)) begin
         steer_p0 = steer(target_p0, ipaddley);
      end

      if (!game_active) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         steer_p0  = 2'b00;
      end else begin
         case (state_p1)
            IDLE: begin
               state_nxt = CENTER;
            end
            CENTER: begin
               if (approaching) begin
                  state_nxt = WAIT;
                  cnt_nxt   = '0;
               end
            end
            WAIT: begin
               if (!approaching) begin
                  state_nxt = CENTER;
                  cnt_nxt   = '0;
               end else if (cnt_p1 == LAST_TICK) begin
                  state_nxt = TRACK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_p1 + 32'd1;
               end
            end
            TRACK: begin
               if (!approaching) begin
                  state_nxt = CENTER;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Stage p1: registered state, reaction counter and paddle requests
   always_ff @(posedge clock or negedge ireset_n) begin
      if (!ireset_n) begin
         state_p1 <= IDLE;
         cnt_p1   <= '0;
         up_p1    <= 1'b0;
         down_p1  <= 1'b0;
      end else begin
         state_p1 <= state_nxt;
         cnt_p1   <= cnt_nxt;
         up_p1    <= steer_p0[1];
         down_p1  <= steer_p0[0];
      end
   end

   assign oup    = up_p1;
   assign odown  = down_p1;
   assign ostate = state_p1;

endmodule

// File: tb/tb_paddle_ai.sv
// Bench for paddle_ai: directed scenarios against hand-derived values, then
// random play against a rule-level reference model.
module tb_paddle_ai;

   localparam int GW = 40;
   localparam int GH = 30;
   localparam int PX = 39;
   localparam int PH = 6;
   localparam int RT = 4;
   localparam int DZ = 1;

   logic       clock = 1'b0;
   logic       ireset_n = 1'b1;
   logic       game_active = 1'b0;
   logic [5:0] iballx = '0;
   logic [5:0] ibally = '0;
   logic       iballdx = 1'b0;
   logic [5:0] ipaddley = '0;
   logic       oup;
   logic       odown;
   logic [1:0] ostate;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 centre, 2 wait, 3 track
   int m_state = 0;
   int m_wait  = 0;
   int m_up    = 0;
   int m_dn    = 0;

   always #5 clock = ~clock;

   paddle_ai #(
      .GAME_WIDTH(GW), .GAME_HEIGHT(GH), .PADDLE_X(PX),
      .PADDLE_HEIGHT(PH), .REACT_TICKS(RT), .DEAD_ZONE(DZ)
   ) dut (
      .clock(clock), .ireset_n(ireset_n), .game_active(game_active),
      .iballx(iballx), .ibally(ibally), .iballdx(iballdx), .ipaddley(ipaddley),
      .oup(oup), .odown(odown), .ostate(ostate)
   );

   task automatic tick();
      int ns, nw, nu, nd, tgt, err;
      bit appr;
      appr = (PX >= GW / 2) ? iballdx : !iballdx;
      ns = m_state; nw = m_wait; nu = 0; nd = 0;
      if (!game_active) begin
         ns = 0; nw = 0;
      end else begin
         if (m_state == 1 || m_state == 3) begin
            tgt = (m_state == 1) ? GH / 2 : int'(ibally);
            err = tgt - (int'(ipaddley) + PH / 2);
            if (err > DZ && int'(ipaddley) < GH - PH) nd = 1;
            if (err < -DZ && ipaddley != 0) nu = 1;
         end
         if (m_state == 0) ns = 1;
         else if (m_state == 1) begin
            if (appr) begin ns = 2; nw = 0; end
         end else if (m_state == 2) begin
            if (!appr) ns = 1;
            else if (m_wait + 1 >= RT) ns = 3;
            else nw = m_wait + 1;
         end else if (!appr) ns = 1;
      end
      @(posedge clock);
      if (!ireset_n) begin
         m_state = 0; m_wait = 0; m_up = 0; m_dn = 0;
      end else begin
         m_state = ns; m_wait = nw; m_up = nu; m_dn = nd;
      end
      #1;
   endtask

   task automatic goto_state(input int s, input string tag);
      int n;
      n = 0;
      while (int'(ostate) != s && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (int'(ostate) != s) begin
         errors++;
         $display("FAIL %s timeout ostate=%0d expected=%0d", tag, ostate, s);
      end
   endtask

   task automatic test_reset();
      #2 ireset_n = 1'b0;
      #1;
      m_state = 0; m_wait = 0; m_up = 0; m_dn = 0;
      checks++;
      if (ostate !== 2'd0 || oup !== 1'b0 || odown !== 1'b0) begin
         errors++;
         $display("FAIL reset_state ostate=%0d up=%b dn=%b expected 0 0 0", ostate, oup, odown);
      end
      game_active = 1'b1;
      tick();
      tick();
      checks++;
      if (ostate !== 2'd0 || oup !== 1'b0 || odown !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold ostate=%0d up=%b dn=%b expected 0 0 0", ostate, oup, odown);
      end
      ireset_n = 1'b1;
      game_active = 1'b0;
      tick();
      checks++;
      if (ostate !== 2'd0) begin
         errors++;
         $display("FAIL inactive_idle ostate=%0d expected=0", ostate);
      end
   endtask

   task automatic test_wait_delay();
      game_active = 1'b1; iballdx = 1'b0; ipaddley = 6'd12; ibally = 6'd15;
      tick();
      checks++;
      if (ostate !== 2'd1) begin
         errors++;
         $display("FAIL idle_to_center ostate=%0d expected=1", ostate);
      end
      iballdx = 1'b1;
      for (int i = 0; i < RT; i++) begin
         tick();
         checks++;
         if (ostate !== 2'd2) begin
            errors++;
            $display("FAIL wait_clock%0d ostate=%0d expected=2", i, ostate);
         end
      end
      tick();
      checks++;
      if (ostate !== 2'd3) begin
         errors++;
         $display("FAIL wait_expiry ostate=%0d expected=3", ostate);
      end
   endtask

   task automatic test_track();
      ipaddley = 6'd10; ibally = 6'd20;
      tick();
      checks++;
      if (odown !== 1'b1 || oup !== 1'b0) begin
         errors++;
         $display("FAIL track_down up=%b dn=%b expected 0 1", oup, odown);
      end
      ibally = 6'd13;
      tick();
      checks++;
      if (odown !== 1'b0 || oup !== 1'b0) begin
         errors++;
         $display("FAIL track_aligned up=%b dn=%b expected 0 0", oup, odown);
      end
      ibally = 6'd14;
      tick();
      checks++;
      if (odown !== 1'b0 || oup !== 1'b0) begin
         errors++;
         $display("FAIL track_deadzone_pos up=%b dn=%b expected 0 0", oup, odown);
      end
      ibally = 6'd12;
      tick();
      checks++;
      if (odown !== 1'b0 || oup !== 1'b0) begin
         errors++;
         $display("FAIL track_deadzone_neg up=%b dn=%b expected 0 0", oup, odown);
      end
      ibally = 6'd5;
      tick();
      checks++;
      if (odown !== 1'b0 || oup !== 1'b1) begin
         errors++;
         $display("FAIL track_up up=%b dn=%b expected 1 0", oup, odown);
      end
   endtask

   task automatic test_limits();
      ipaddley = 6'd0; ibally = 6'd0;
      tick();
      checks++;
      if (oup !== 1'b0 || odown !== 1'b0) begin
         errors++;
         $display("FAIL top_limit up=%b dn=%b expected 0 0", oup, odown);
      end
      ipaddley = 6'd24; ibally = 6'd29;
      tick();
      checks++;
      if (oup !== 1'b0 || odown !== 1'b0) begin
         errors++;
         $display("FAIL bottom_limit up=%b dn=%b expected 0 0", oup, odown);
      end
      ipaddley = 6'd23;
      tick();
      checks++;
      if (oup !== 1'b0 || odown !== 1'b1) begin
         errors++;
         $display("FAIL above_bottom up=%b dn=%b expected 0 1", oup, odown);
      end
   endtask

   task automatic test_async_reset();
      ipaddley = 6'd10; ibally = 6'd20;
      tick();
      checks++;
      if (odown !== 1'b1 || ostate !== 2'd3) begin
         errors++;
         $display("FAIL pre_reset dn=%b ostate=%0d expected 1 3", odown, ostate);
      end
      #2 ireset_n = 1'b0;
      #1;
      m_state = 0; m_wait = 0; m_up = 0; m_dn = 0;
      checks++;
      if (oup !== 1'b0 || odown !== 1'b0 || ostate !== 2'd0) begin
         errors++;
         $display("FAIL async_reset up=%b dn=%b ostate=%0d expected 0 0 0", oup, odown, ostate);
      end
      ireset_n = 1'b1;
   endtask

   task automatic test_abort_wait();
      game_active = 1'b1; iballdx = 1'b0; ipaddley = 6'd12; ibally = 6'd15;
      goto_state(1, "abort_center");
      iballdx = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (ostate !== 2'd2) begin
         errors++;
         $display("FAIL abort_in_wait ostate=%0d expected=2", ostate);
      end
      iballdx = 1'b0;
      tick();
      checks++;
      if (ostate !== 2'd1) begin
         errors++;
         $display("FAIL abort_to_center ostate=%0d expected=1", ostate);
      end
      iballdx = 1'b1;
      for (int i = 0; i < RT; i++) begin
         tick();
         checks++;
         if (ostate !== 2'd2) begin
            errors++;
            $display("FAIL rewait_clock%0d ostate=%0d expected=2", i, ostate);
         end
      end
      tick();
      checks++;
      if (ostate !== 2'd3) begin
         errors++;
         $display("FAIL rewait_expiry ostate=%0d expected=3", ostate);
      end
   endtask

   task automatic test_center_and_idle();
      iballdx = 1'b0; ipaddley = 6'd2;
      goto_state(1, "center_entry");
      tick();
      checks++;
      if (odown !== 1'b1 || oup !== 1'b0) begin
         errors++;
         $display("FAIL center_down up=%b dn=%b expected 0 1", oup, odown);
      end
      iballdx = 1'b1;
      tick();
      checks++;
      if (ostate !== 2'd2 || odown !== 1'b1) begin
         errors++;
         $display("FAIL wait_entry_edge ostate=%0d dn=%b expected 2 1", ostate, odown);
      end
      tick();
      checks++;
      if (odown !== 1'b0) begin
         errors++;
         $display("FAIL wait_forced_zero dn=%b expected 0", odown);
      end
      iballdx = 1'b0;
      tick();
      tick();
      checks++;
      if (ostate !== 2'd1 || odown !== 1'b1) begin
         errors++;
         $display("FAIL recentre ostate=%0d dn=%b expected 1 1", ostate, odown);
      end
      game_active = 1'b0;
      tick();
      checks++;
      if (ostate !== 2'd0 || odown !== 1'b0 || oup !== 1'b0) begin
         errors++;
         $display("FAIL game_off ostate=%0d up=%b dn=%b expected 0 0 0", ostate, oup, odown);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         game_active = ($urandom_range(0, 31) != 0);
         if ($urandom_range(0, 7) == 0) iballdx = ~iballdx;
         iballx = 6'($urandom_range(0, GW - 1));
         ibally = 6'($urandom_range(0, GH - 1));
         case ($urandom_range(0, 5))
            0: ipaddley = 6'd0;
            1: ipaddley = 6'(GH - PH);
            2: ipaddley = 6'($urandom_range(0, 63));
            default: ipaddley = 6'($urandom_range(0, GH - PH));
         endcase
         tick();
         checks++;
         if (int'(ostate) != m_state || int'(oup) != m_up || int'(odown) != m_dn || (oup && odown)) begin
            errors++;
            $display("FAIL random_%0d ostate=%0d up=%b dn=%b expected %0d %0d %0d",
                     i, ostate, oup, odown, m_state, m_up, m_dn);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wait_delay();
      test_track();
      test_limits();
      test_async_reset();
      test_abort_wait();
      test_center_and_idle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
